// File: rtl/updown_counter_param_pkg.sv
// Shared encodings for the parametrised up/down counter: terminal-count modes and FSM states.
package updown_counter_param_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/updown_counter_param.sv
// Up/down counter with programmable modulus, parallel load, synchronous clear
// and wrap / saturate / one-shot terminal handling. All outputs registered.
module updown_counter_param
  import updown_counter_param_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_VAL   = 2**WIDTH - 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output logic             halted,
  output logic             load_err
);

  if ((MAX_VAL < 1) || (longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_max
    $error("updown_counter_param: MAX_VAL out of range for WIDTH");
  end
  if (RESET_VAL > MAX_VAL) begin : g_bad_rst
    $error("updown_counter_param: RESET_VAL exceeds MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

  state_e           state;
  mode_e            mode_q;
  logic             at_term;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] wrap_val;

  assign mode_q = mode_e'(mode);

  // Wrap is modulo MAX_VAL+1, so the terminal values are swapped explicitly
  // instead of relying on natural 2**WIDTH overflow.
  always_comb begin
    at_term  = 1'b0;
    step_val = cnt_out;
    wrap_val = cnt_out;
    if (up_down) begin
      at_term  = (cnt_out == MAX_W);
      step_val = cnt_out + 1'b1;
      wrap_val = '0;
    end else begin
      at_term  = (cnt_out == '0);
      step_val = cnt_out - 1'b1;
      wrap_val = MAX_W;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_out  <= RST_W;
      tc       <= 1'b0;
      halted   <= 1'b0;
      load_err <= 1'b0;
      state    <= ST_RUN;
    end else begin
      tc       <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        cnt_out <= '0;
        state   <= ST_RUN;
        halted  <= 1'b0;
      end else if (load) begin
        if (load_val > MAX_W) begin
          cnt_out  <= MAX_W;
          load_err <= 1'b1;
        end else begin
          cnt_out <= load_val;
        end
        state  <= ST_RUN;
        halted <= 1'b0;
      end else if (en && (state == ST_RUN)) begin
        if (at_term) begin
          tc <= 1'b1;
          case (mode_q)
            MODE_SAT: cnt_out <= cnt_out;
            MODE_ONESHOT: begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
            default: cnt_out <= wrap_val;
          endcase
        end else begin
          cnt_out <= step_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param with WIDTH=4, MAX_VAL=9, RESET_VAL=0.
module tb_updown_counter_param;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_down;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic [1:0] mode;
  logic [3:0] cnt_out;
  logic       tc;
  logic       halted;
  logic       load_err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  updown_counter_param #(
    .WIDTH    (4),
    .MAX_VAL  (9),
    .RESET_VAL(0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .up_down (up_down),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .mode    (mode),
    .cnt_out (cnt_out),
    .tc      (tc),
    .halted  (halted),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int c, input int t, input int h, input int le);
    chk({tag, ".cnt"}, 32'(cnt_out), 32'(c));
    chk({tag, ".tc"}, 32'(tc), 32'(t));
    chk({tag, ".halted"}, 32'(halted), 32'(h));
    chk({tag, ".load_err"}, 32'(load_err), 32'(le));
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up_down = 1'b1; clr = 1'b0; load = 1'b0;
    load_val = '0; mode = 2'b00;
    step(); step();
    chk_all("rst_init", 0, 0, 0, 0);
    reset = 1'b1;

    // 1: mid-count asynchronous reset
    en = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("pre_rst.cnt", 32'(cnt_out), 6);
    #3 reset = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("rst_hold", 0, 0, 0, 0);
    end
    #2 reset = 1'b1;

    // 2: wrap up then down
    for (int i = 1; i <= 10; i++) begin
      step();
      chk_all("wrap_up", i % 10, (i == 10) ? 1 : 0, 0, 0);
    end
    up_down = 1'b0;
    step(); chk_all("wrap_dn0", 9, 1, 0, 0);
    step(); chk_all("wrap_dn1", 8, 0, 0, 0);

    // 3: saturate at top, then reverse
    mode = 2'b01; up_down = 1'b1;
    step(); chk_all("sat_up", 9, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("sat_pin", 9, 1, 0, 0);
    end
    up_down = 1'b0;
    step(); chk_all("sat_rev", 8, 0, 0, 0);

    // 4: one-shot countdown
    mode = 2'b10; en = 1'b0; load = 1'b1; load_val = 4'd3;
    step(); chk_all("os_load", 3, 0, 0, 0);
    load = 1'b0; en = 1'b1; up_down = 1'b0;
    step(); chk_all("os_2", 2, 0, 0, 0);
    step(); chk_all("os_1", 1, 0, 0, 0);
    step(); chk_all("os_0", 0, 0, 0, 0);
    step(); chk_all("os_term", 0, 1, 1, 0);
    mode = 2'b00; up_down = 1'b1;
    step(); chk_all("os_frz_wrap", 0, 0, 1, 0);
    mode = 2'b01; en = 1'b0;
    step(); chk_all("os_frz_sat", 0, 0, 1, 0);
    en = 1'b1; load = 1'b1; load_val = 4'd5;
    step(); chk_all("os_reload", 5, 0, 0, 0);

    // 5: load boundaries
    mode = 2'b00; en = 1'b0; load_val = 4'd12;
    step(); chk_all("ld_over", 9, 0, 0, 1);
    load = 1'b0;
    step(); chk_all("ld_err_clr", 9, 0, 0, 0);
    clr = 1'b1; load = 1'b1; load_val = 4'd12;
    step(); chk_all("clr_wins", 0, 0, 0, 0);
    clr = 1'b0; load_val = 4'd7;
    step(); chk_all("ld_en0", 7, 0, 0, 0);
    load_val = 4'd9;
    step(); chk_all("ld_max", 9, 0, 0, 0);
    load_val = 4'd10;
    step(); chk_all("ld_max1", 9, 0, 0, 1);

    // SAT at bottom pins at 0
    load = 1'b0; clr = 1'b1;
    step(); chk_all("clr", 0, 0, 0, 0);
    clr = 1'b0; mode = 2'b01; en = 1'b1; up_down = 1'b0;
    step(); chk_all("sat_bot", 0, 1, 0, 0);

    // reserved mode behaves as wrap
    mode = 2'b11;
    step(); chk_all("rsvd_wrap", 9, 1, 0, 0);

    // 6: enable hold and direction toggling
    mode = 2'b00; load = 1'b1; load_val = 4'd4; en = 1'b0;
    step(); chk("ld4.cnt", 32'(cnt_out), 4);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); chk_all("en_hold", 4, 0, 0, 0);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_down = (i % 2 == 0) ? 1'b1 : 1'b0;
      step(); chk_all("toggle", (i % 2 == 0) ? 5 : 4, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
